aes_round_ctrl: RTL

- Iterative AES-128 encryption controller: holds the 128-bit state register and round counter.
- Fetches round keys from an external key-schedule block over a request/valid handshake.
- Applies one round of the combinational round datapath (sub_bytes -> shift_rows -> mix_columns -> add_round_key) per accepted key.
- Sits between the block-input stream and the ciphertext output stream of the AES core.

---
 rtl/aes_pkg.sv | 35 +++
 rtl/aes_round_datapath.sv | 44 ++++
 rtl/aes_round_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 constants, controller state encoding and GF(2^8) byte helpers.
// Blocks are [0:127] vectors: bit 0 is the MSB and byte k is blk[8k+:8].
package aes_pkg;

    localparam int unsigned NR     = 10;
    localparam int unsigned RIDX_W = 4;
    localparam int unsigned BLK_W  = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } fsm_e;

    // FIPS-197 S-box, entry b at bits [8b +: 8].
    localparam logic [0:2047] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_round_datapath.sv
// One combinational AES encryption round: sub_bytes, shift_rows, mix_columns, key XOR.
// first keeps only the key XOR (initial whitening); last skips mix_columns.
module aes_round_datapath
    import aes_pkg::*;
(
    input  logic [0:BLK_W-1] state,
    input  logic [0:BLK_W-1] key,
    input  logic             first,
    input  logic             last,
    output logic [0:BLK_W-1] result
);

    logic [0:BLK_W-1] sb, sr, mc, pre;
    logic [7:0]       col [4];

    always_comb begin
        sb  = '0;
        sr  = '0;
        mc  = '0;
        col = '{default: '0};
        for (int k = 0; k < 16; k++) begin
            sb[8*k +: 8] = sbox(state[8*k +: 8]);
        end
        // Row r of column c takes the byte from column (c + r) mod 4.
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[8*(4*c+r) +: 8] = sb[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                col[i] = sr[32*c+8*i +: 8];
            end
            mc[32*c    +: 8] = xtime(col[0]) ^ xtime(col[1]) ^ col[1] ^ col[2] ^ col[3];
            mc[32*c+8  +: 8] = col[0] ^ xtime(col[1]) ^ xtime(col[2]) ^ col[2] ^ col[3];
            mc[32*c+16 +: 8] = col[0] ^ col[1] ^ xtime(col[2]) ^ xtime(col[3]) ^ col[3];
            mc[32*c+24 +: 8] = xtime(col[0]) ^ col[0] ^ col[1] ^ col[2] ^ xtime(col[3]);
        end
    end

    assign pre    = first ? state : (last ? sr : mc);
    assign result = pre ^ key;

endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption controller: one round per accepted round key,
// ciphertext held on the output until downstream accepts it.
module aes_round_ctrl #(
    parameter int unsigned NR     = aes_pkg::NR,
    parameter int unsigned RIDX_W = aes_pkg::RIDX_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [0:aes_pkg::BLK_W-1] in_data,
    output logic                      key_req,
    output logic [RIDX_W-1:0]         key_idx,
    input  logic                      key_valid,
    input  logic [0:aes_pkg::BLK_W-1] round_key,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [0:aes_pkg::BLK_W-1] out_data,
    output logic                      busy
);
    import aes_pkg::*;

    localparam logic [RIDX_W-1:0] LastRound = RIDX_W'(NR);

    fsm_e              fsm_q, fsm_d;
    logic [0:BLK_W-1]  state_q, state_d, round_out;
    logic [RIDX_W-1:0] round_q, round_d;
    logic              first, last;

    assign first = (round_q == '0);
    assign last  = (round_q == LastRound);

    aes_round_datapath u_datapath (
        .state  (state_q),
        .key    (round_key),
        .first  (first),
        .last   (last),
        .result (round_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        key_req   = 1'b0;
        key_idx   = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b0;
        unique case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_data;
                    round_d = '0;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                key_req = 1'b1;
                key_idx = round_q;
                busy    = 1'b1;
                if (key_valid) begin
                    state_d = round_out;
                    if (last) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + 1'b1;
                    end
                end
            end
            DONE: begin
                // state_q reaches the output only here so partial rounds never leak.
                out_valid = 1'b1;
                out_data  = state_q;
                busy      = 1'b1;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

endmodule
